// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the model-RAM controller slice: FSM encoding and
// default RAM geometry, also used by the RAM wrapper.
package ram_ctrl_pkg;

  localparam int unsigned ADDR_SIZE = 4;
  localparam int unsigned WORD_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } ram_state_e;

endpackage : ram_ctrl_pkg

// File: rtl/rr_arb2.sv
// Two-input round-robin pick: on a tie the client not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 && req1) ? ~last_gnt : req1;
  end

endmodule : rr_arb2

// File: rtl/ram_arbiter2.sv
// Two-client arbiter/sequencer for the asynchronous-read model RAM:
// IDLE -> ACCESS (one RAM cycle) -> ACK (completion pulse), all outputs registered.
module ram_arbiter2
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned addr_size = ADDR_SIZE,
  parameter int unsigned word_size = WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 wr0,
  input  logic [addr_size-1:0] addr0,
  input  logic [word_size-1:0] wdata0,
  input  logic                 req1,
  input  logic                 wr1,
  input  logic [addr_size-1:0] addr1,
  input  logic [word_size-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [word_size-1:0] rdata,
  output logic [addr_size-1:0] ram_addr,
  output logic [word_size-1:0] ram_data_in,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [word_size-1:0] ram_data_out
);

  ram_state_e           state_q, state_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 wr_q, wr_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic [word_size-1:0] rdata_q, rdata_d;
  logic [addr_size-1:0] ram_addr_q, ram_addr_d;
  logic [word_size-1:0] ram_data_in_q, ram_data_in_d;
  logic                 ram_wr_q, ram_wr_d;
  logic                 ram_cs_q, ram_cs_d;

  logic gnt_valid;
  logic gnt_id;

  rr_arb2 u_rr_arb2 (
    .req0      (req0),
    .req1      (req1),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    wr_d          = wr_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata_d       = rdata_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    ram_wr_d      = 1'b0;
    ram_cs_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d       = ACCESS;
          last_gnt_d    = gnt_id;
          wr_d          = gnt_id ? wr1 : wr0;
          ram_addr_d    = gnt_id ? addr1 : addr0;
          ram_data_in_d = gnt_id ? wdata1 : wdata0;
          ram_wr_d      = gnt_id ? wr1 : wr0;
          ram_cs_d      = 1'b1;
        end
      end
      ACCESS: begin
        // Address/data are held into ACK so the level-sensitive RAM sees wr fall first.
        state_d = ACK;
        if (!wr_q) begin
          rdata_d = ram_data_out;
        end
        ack0_d = ~last_gnt_q;
        ack1_d = last_gnt_q;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_gnt_q    <= 1'b1;
      wr_q          <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata_q       <= '0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      ram_wr_q      <= 1'b0;
      ram_cs_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      wr_q          <= wr_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata_q       <= rdata_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      ram_wr_q      <= ram_wr_d;
      ram_cs_q      <= ram_cs_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign ram_wr      = ram_wr_q;
  assign ram_cs      = ram_cs_q;

endmodule : ram_arbiter2

// File: tb/tb_ram_arbiter2.sv
// Bench for ram_arbiter2: directed scenarios plus random client traffic,
// checked against a transaction-level model of arbitration and RAM contents.
module tb_ram_arbiter2;
  import ram_ctrl_pkg::*;

  localparam int unsigned AW = ADDR_SIZE;
  localparam int unsigned DW = WORD_SIZE;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_wr, ram_cs;
  logic [DW-1:0] ram_data_out;

  ram_arbiter2 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0),
    .wr0          (wr0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .req1         (req1),
    .wr1          (wr1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .ack0         (ack0),
    .ack1         (ack1),
    .rdata        (rdata),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_wr       (ram_wr),
    .ram_cs       (ram_cs),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment RAM: asynchronous read, write while cs and wr are high at the edge.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_cs && ram_wr) ram_mem[ram_addr] <= ram_data_in;
  end
  assign ram_data_out = ram_mem[ram_addr];

  // Reference model state: pending client operations, expected memory and rdata.
  bit            pend    [2];
  bit            just    [2];
  logic          op_wr   [2];
  logic [AW-1:0] op_addr [2];
  logic [DW-1:0] op_data [2];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_rdata;
  bit            last_w;
  int            ack_cnt [2];
  bit            auto_gen;
  int unsigned   gen_pct;
  int            n_checks;
  int            n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_client(input int i, input logic rq, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (i == 0) begin
      req0 = rq; wr0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = rq; wr1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic queue_op(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    pend[i] = 1'b1; op_wr[i] = w; op_addr[i] = a; op_data[i] = d;
  endtask

  // One arbitration slot, entered and left at the negedge of an IDLE cycle.
  task automatic run_slot();
    bit act [2];
    bit w;
    for (int i = 0; i < 2; i++) begin
      if (auto_gen && !pend[i] && !just[i] && ($urandom_range(99) < gen_pct))
        queue_op(i, 1'($urandom_range(1)), AW'($urandom), DW'($urandom));
      act[i] = pend[i] && !just[i];
      just[i] = 1'b0;
      if (act[i]) set_client(i, 1'b1, op_wr[i], op_addr[i], op_data[i]);
      else        set_client(i, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    chk("idle_cs", 32'(ram_cs), 32'd0);
    chk("idle_wr", 32'(ram_wr), 32'd0);
    chk("idle_acks", 32'({ack1, ack0}), 32'd0);
    if (!act[0] && !act[1]) begin
      @(negedge clk);
      return;
    end
    w = (act[0] && act[1]) ? ~last_w : act[1];

    @(negedge clk);  // ACCESS
    chk("acc_cs", 32'(ram_cs), 32'd1);
    chk("acc_wr", 32'(ram_wr), 32'(op_wr[w]));
    chk("acc_addr", 32'(ram_addr), 32'(op_addr[w]));
    chk("acc_data", 32'(ram_data_in), 32'(op_data[w]));
    chk("acc_acks", 32'({ack1, ack0}), 32'd0);
    if (op_wr[w]) ref_mem[op_addr[w]] = op_data[w];
    else          exp_rdata = ref_mem[op_addr[w]];
    set_client(int'(w), 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));

    @(negedge clk);  // ACK
    chk("ack_acks", 32'({ack1, ack0}), w ? 32'd2 : 32'd1);
    chk("ack_cs", 32'(ram_cs), 32'd0);
    chk("ack_wr", 32'(ram_wr), 32'd0);
    chk("ack_addr_hold", 32'(ram_addr), 32'(op_addr[w]));
    chk("ack_data_hold", 32'(ram_data_in), 32'(op_data[w]));
    chk("ack_rdata", 32'(rdata), 32'(exp_rdata));
    ack_cnt[0] += int'(ack0);
    ack_cnt[1] += int'(ack1);
    pend[w] = 1'b0;
    just[w] = 1'b1;
    last_w  = w;
    @(negedge clk);
  endtask

  task automatic do_op(input int i, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    queue_op(i, w, a, d);
    for (int k = 0; k < 4 && pend[i]; k++) run_slot();
    chk("op_served", 32'(pend[i]), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    auto_gen = 1'b0; gen_pct = 60;
    last_w = 1'b1; exp_rdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram_mem[i] = '0; ref_mem[i] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; just[i] = 1'b0; ack_cnt[i] = 0;
    end

    // Reset held with a pending request: nothing may move.
    rst_n = 1'b0;
    set_client(0, 1'b1, 1'b0, AW'(5), DW'(0));
    set_client(1, 1'b0, 1'b0, AW'(0), DW'(0));
    repeat (2) begin
      @(negedge clk);
      chk("rst_acks", 32'({ack1, ack0}), 32'd0);
      chk("rst_cs_wr", 32'({ram_cs, ram_wr}), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_din", 32'(ram_data_in), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
    end
    rst_n = 1'b1;
    queue_op(0, 1'b0, AW'(5), DW'(0));
    run_slot();

    // Single write then read back by client 0.
    do_op(0, 1'b1, AW'(3), DW'(8'hA5));
    do_op(0, 1'b0, AW'(3), DW'(0));
    chk("wr_rd_a5", 32'(rdata), 32'hA5);

    // Continuous contention: grants must alternate, two acks each.
    queue_op(0, 1'b1, AW'(1), DW'(8'h11));
    queue_op(1, 1'b1, AW'(2), DW'(8'h22));
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) queue_op(i, 1'($urandom_range(1)), AW'($urandom), DW'($urandom));
      run_slot();
    end
    chk("fair_cnt0", 32'(ack_cnt[0]), 32'd2);
    chk("fair_cnt1", 32'(ack_cnt[1]), 32'd2);
    while (pend[0] || pend[1] || just[0] || just[1]) run_slot();

    // Client 1 served last, then a tie: client 0 must go first.
    do_op(1, 1'b0, AW'(1), DW'(0));
    chk("rd_11", 32'(rdata), 32'h11);
    run_slot();
    queue_op(0, 1'b0, AW'(2), DW'(0));
    queue_op(1, 1'b0, AW'(1), DW'(0));
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    run_slot();
    chk("rr_tie_first0", 32'(ack_cnt[0]), 32'd1);
    chk("rd_22", 32'(rdata), 32'h22);
    run_slot();

    // Address boundaries.
    do_op(0, 1'b1, AW'(4'hF), DW'(8'hFF));
    do_op(1, 1'b1, AW'(0), DW'(8'h00));
    do_op(0, 1'b0, AW'(4'hF), DW'(0));
    chk("rd_top", 32'(rdata), 32'hFF);
    do_op(1, 1'b0, AW'(0), DW'(0));
    chk("rd_bottom", 32'(rdata), 32'h00);

    // Reset during the ACCESS cycle of a read.
    run_slot();
    run_slot();
    queue_op(0, 1'b0, AW'(4'hF), DW'(0));
    set_client(0, 1'b1, 1'b0, AW'(4'hF), DW'(0));
    set_client(1, 1'b0, 1'b0, AW'(0), DW'(0));
    @(negedge clk);
    chk("mr_access_cs", 32'(ram_cs), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_no_ack", 32'({ack1, ack0}), 32'd0);
    chk("mr_cs_wr", 32'({ram_cs, ram_wr}), 32'd0);
    chk("mr_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    exp_rdata = '0;
    last_w = 1'b1;
    run_slot();
    chk("mr_resume", 32'(rdata), 32'hFF);

    // Random traffic from both clients.
    auto_gen = 1'b1;
    repeat (300) run_slot();
    auto_gen = 1'b0;
    repeat (4) run_slot();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ram_arbiter2
